// File: rtl/waterfall_sequencer_if.sv
// waterfall_sequencer_if: control/command bundle between a host and the waterfall sequencer
// Ports (master drives): start, stop, pause, mode[1:0], pattern[7:0], rate[DIV_W-1:0]
// Ports (slave drives):  S1, S0, D[7:0], busy, step_tick, pos[2:0]
interface waterfall_sequencer_if #(parameter int DIV_W = 4);
  logic start, stop, pause;
  logic [1:0] mode;
  logic [7:0] pattern;
  logic [DIV_W-1:0] rate;
  logic S1, S0;
  logic [7:0] D;
  logic busy, step_tick;
  logic [2:0] pos;
  modport master(output start, stop, pause, mode, pattern, rate,
                 input S1, S0, D, busy, step_tick, pos);
  modport slave(input start, stop, pause, mode, pattern, rate,
                output S1, S0, D, busy, step_tick, pos);
endinterface

// File: rtl/waterfall_sequencer.sv
// waterfall_sequencer: loads a start pattern into a mode-controlled shift register, then issues timed shift commands
// Ports: CP clock (posedge), CR async active-low reset, bus slave modport carrying
//        start/stop/pause/mode/pattern/rate in and {S1,S0}/D/busy/step_tick/pos out (all outputs registered)
module waterfall_sequencer #(parameter int DIV_W = 4) (
  input logic CP,
  input logic CR,
  waterfall_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2;
  logic [1:0] state, lmode, cmd;
  logic [DIV_W-1:0] lrate, presc;
  logic dir, tick;
  logic [2:0] pos_nx;
  always_comb begin
    tick = presc == lrate;
    cmd = (lmode == 2'b01 || (lmode == 2'b10 && dir)) ? 2'b10 : 2'b01;
    pos_nx = cmd == 2'b10 ? bus.pos - 3'd1 : bus.pos + 3'd1;
  end
  // The edge leaving LOAD already counts as the first prescaler cycle, so rate=0 shifts right after the load.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state <= IDLE;
      lmode <= '0;
      lrate <= '0;
      presc <= '0;
      dir <= 1'b0;
      {bus.S1, bus.S0} <= 2'b00;
      bus.D <= '0;
      bus.busy <= 1'b0;
      bus.step_tick <= 1'b0;
      bus.pos <= '0;
    end else if (bus.stop) begin
      state <= IDLE;
      {bus.S1, bus.S0} <= 2'b00;
      bus.busy <= 1'b0;
      bus.step_tick <= 1'b0;
    end else if (bus.start) begin
      state <= LOAD;
      lmode <= bus.mode;
      lrate <= bus.rate;
      presc <= '0;
      dir <= 1'b0;
      {bus.S1, bus.S0} <= 2'b11;
      bus.D <= bus.pattern;
      bus.busy <= 1'b1;
      bus.step_tick <= 1'b0;
      bus.pos <= '0;
    end else if (state == IDLE) begin
      {bus.S1, bus.S0} <= 2'b00;
      bus.busy <= 1'b0;
      bus.step_tick <= 1'b0;
    end else begin
      state <= RUN;
      {bus.S1, bus.S0} <= 2'b00;
      bus.step_tick <= 1'b0;
      if (!bus.pause) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          {bus.S1, bus.S0} <= cmd;
          bus.step_tick <= 1'b1;
          bus.pos <= pos_nx;
          if (lmode == 2'b10 && pos_nx == (dir ? 3'd0 : 3'd7)) dir <= ~dir;
          // One-shot: the 7th command still goes out; busy drops on the following IDLE cycle.
          if (lmode == 2'b11 && pos_nx == 3'd7) state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_waterfall_sequencer.sv
// tb_waterfall_sequencer: randomized self-checking bench against a step-count reference model
module tb_waterfall_sequencer;
  logic CP = 1'b0, CR = 1'b0;
  int n_vec = 0, n_err = 0;
  waterfall_sequencer_if #(.DIV_W(4)) bus();
  waterfall_sequencer #(.DIV_W(4)) dut(.CP(CP), .CR(CR), .bus(bus));
  always #5 CP = ~CP;

  int m_state, m_mode, m_rate, steps, active;
  logic [1:0] e_s;
  logic [7:0] e_d;
  logic e_busy, e_tick;
  logic [2:0] e_pos;
  wire [14:0] got = {bus.S1, bus.S0, bus.D, bus.busy, bus.step_tick, bus.pos};
  wire [14:0] expv = {e_s, e_d, e_busy, e_tick, e_pos};

  function automatic logic [2:0] pos_of(int md, int n);
    int k;
    k = n % 14;
    return md == 0 ? 3'(n % 8) : md == 1 ? 3'((8 - n % 8) % 8) : md == 2 ? 3'(k <= 7 ? k : 14 - k) : 3'(n);
  endfunction
  function automatic logic [1:0] cmd_of(int md, int n);
    return (md == 1 || (md == 2 && (n - 1) % 14 >= 7)) ? 2'b10 : 2'b01;
  endfunction

  // Reference: position and command are pure functions of the number of steps taken since the load;
  // a step happens on every (rate+1)-th unpaused cycle after the load cycle.
  always @(posedge CP or negedge CR) begin
    if (!CR) begin
      m_state <= 0; m_mode <= 0; m_rate <= 0; steps <= 0; active <= 0;
      e_s <= 2'b00; e_d <= 8'h00; e_busy <= 1'b0; e_tick <= 1'b0; e_pos <= 3'd0;
    end else if (bus.stop) begin
      m_state <= 0; e_s <= 2'b00; e_busy <= 1'b0; e_tick <= 1'b0;
    end else if (bus.start) begin
      m_state <= 1; m_mode <= int'(bus.mode); m_rate <= int'(bus.rate); steps <= 0; active <= 0;
      e_s <= 2'b11; e_d <= bus.pattern; e_busy <= 1'b1; e_tick <= 1'b0; e_pos <= 3'd0;
    end else if (m_state == 0) begin
      e_s <= 2'b00; e_busy <= 1'b0; e_tick <= 1'b0;
    end else begin
      m_state <= 2; e_s <= 2'b00; e_tick <= 1'b0;
      if (!bus.pause) begin
        active <= active + 1;
        if (active % (m_rate + 1) == m_rate) begin
          steps <= steps + 1;
          e_tick <= 1'b1;
          e_s <= cmd_of(m_mode, steps + 1);
          e_pos <= pos_of(m_mode, steps + 1);
          if (m_mode == 3 && steps + 1 == 7) m_state <= 0;
        end
      end
    end
  end

  task automatic idle_inputs;
    bus.start = 0; bus.stop = 0; bus.pause = 0;
  endtask

  task automatic test_reset;
    idle_inputs(); bus.mode = 0; bus.pattern = 8'h00; bus.rate = 0;
    CR = 0;
    @(negedge CP);
    n_vec++;
    if (got !== 15'd0) begin n_err++; $display("FAIL reset_por got=%h exp=%h", got, 15'd0); end
    CR = 1;
    bus.mode = 0; bus.pattern = 8'h3c; bus.rate = 1; bus.start = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge CP);
      bus.start = 0;
      n_vec++;
      if (got !== expv) begin n_err++; $display("FAIL reset_prerun cyc%0d got=%h exp=%h", i, got, expv); end
    end
    #2 CR = 0;
    #1 n_vec++;
    if ({bus.S1, bus.S0, bus.busy, bus.pos, bus.D} !== 14'd0)
      begin n_err++; $display("FAIL reset_async got=%h exp=0", {bus.S1, bus.S0, bus.busy, bus.pos, bus.D}); end
    @(negedge CP);
    CR = 1;
  endtask

  task automatic test_rotate_left;
    bus.mode = 2'b00; bus.pattern = 8'h01; bus.rate = 0; bus.start = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CP);
      bus.start = 0;
      n_vec++;
      if (got !== expv) begin n_err++; $display("FAIL rotate_left cyc%0d got=%h exp=%h", i, got, expv); end
    end
  endtask

  task automatic test_rotate_right;
    bus.mode = 2'b01; bus.pattern = 8'($urandom); bus.rate = 3; bus.start = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CP);
      bus.start = 0;
      bus.mode = 2'($urandom); bus.rate = 4'($urandom);
      n_vec++;
      if (got !== expv) begin n_err++; $display("FAIL rotate_right cyc%0d got=%h exp=%h", i, got, expv); end
    end
  endtask

  task automatic test_bounce;
    bus.mode = 2'b10; bus.pattern = 8'($urandom); bus.rate = 0; bus.start = 1;
    for (int i = 0; i < 26; i++) begin
      @(negedge CP);
      bus.start = 0;
      n_vec++;
      if (got !== expv) begin n_err++; $display("FAIL bounce cyc%0d got=%h exp=%h", i, got, expv); end
    end
  endtask

  task automatic test_oneshot;
    bus.mode = 2'b11; bus.pattern = 8'($urandom); bus.rate = 1; bus.start = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge CP);
      bus.start = 0;
      n_vec++;
      if (got !== expv) begin n_err++; $display("FAIL oneshot cyc%0d got=%h exp=%h", i, got, expv); end
    end
  endtask

  task automatic test_pause;
    bus.mode = 2'b00; bus.pattern = 8'($urandom); bus.rate = 2; bus.start = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CP);
      bus.start = 0;
      bus.pause = i >= 6 && i < 11;
      n_vec++;
      if (got !== expv) begin n_err++; $display("FAIL pause cyc%0d got=%h exp=%h", i, got, expv); end
    end
    bus.pause = 0;
  endtask

  task automatic test_stop;
    bus.mode = 2'b01; bus.pattern = 8'($urandom); bus.rate = 0; bus.start = 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge CP);
      bus.start = 0;
      bus.stop = i == 5;
      n_vec++;
      if (got !== expv) begin n_err++; $display("FAIL stop cyc%0d got=%h exp=%h", i, got, expv); end
    end
    bus.stop = 0;
  endtask

  task automatic test_restart;
    bus.mode = 2'b10; bus.pattern = 8'($urandom); bus.rate = 1; bus.start = 1;
    for (int i = 0; i < 18; i++) begin
      @(negedge CP);
      bus.start = i == 8;
      if (i == 8) begin bus.pattern = 8'h81; bus.mode = 2'($urandom); bus.rate = 4'($urandom_range(0, 2)); end
      n_vec++;
      if (got !== expv) begin n_err++; $display("FAIL restart cyc%0d got=%h exp=%h", i, got, expv); end
    end
    bus.start = 0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      bus.start = $urandom_range(0, 99) < 3;
      bus.stop = $urandom_range(0, 99) < 2;
      bus.pause = $urandom_range(0, 99) < 20;
      bus.mode = 2'($urandom); bus.pattern = 8'($urandom); bus.rate = 4'($urandom_range(0, 5));
      @(negedge CP);
      n_vec++;
      if (got !== expv) begin n_err++; $display("FAIL random cyc%0d got=%h exp=%h", i, got, expv); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_bounce();
    test_oneshot();
    test_pause();
    test_stop();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
